// File: rtl/ram_line_pkg.sv
// rtl/ram_line_pkg.sv - shared constants, encodings and helpers for the RAM line extractor
//
// Purpose : line geometry, load-size encodings, FSM state type and a
//           byte-count helper shared by the extractor top and its lane mux.
// Ports   : none (package).
package ram_line_pkg;

   localparam int LINE_BYTES = 128;
   localparam int OFFS_WIDTH = 7;
   localparam int LINE_BITS  = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } size_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SECOND = 1'b1
   } state_e;

   // 1, 2, 4 or 8 bytes for the four load sizes.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/ram_line_extractor_byte_lane.sv
// rtl/ram_line_extractor_byte_lane.sv - combinational byte-lane select, split merge and extension
//
// Purpose : picks up to eight bytes starting at a byte offset of a RAM line,
//           optionally places them above a number of previously held low
//           bytes, then truncates to the load size and zero/sign-extends.
// Ports   :
//   line_i     [1023:0] RAM line, byte i at [8i+7:8i]
//   offs_i     [6:0]    byte offset of the first selected byte
//   size_i     [1:0]    load size encoding
//   signed_i            sign-extend when set (ignored for 8-byte loads)
//   held_i     [63:0]   low bytes captured from a previous line
//   held_cnt_i [2:0]    number of valid bytes in held_i (0 = no merge)
//   raw_o      [63:0]   bytes offs..offs+7 of the line, zero past byte 127
//   data_o     [63:0]   merged, truncated and extended element
module byte_lane_extract
   import ram_line_pkg::*;
(
   input  logic [LINE_BITS-1:0] line_i,
   input  logic [OFFS_WIDTH-1:0] offs_i,
   input  logic [1:0]           size_i,
   input  logic                 signed_i,
   input  logic [63:0]          held_i,
   input  logic [2:0]           held_cnt_i,
   output logic [63:0]          raw_o,
   output logic [63:0]          data_o
);

   logic [63:0] held_mask;
   logic [63:0] merged;

   always_comb begin
      raw_o = 64'd0;
      for (int b = 0; b < 8; b++) begin
         logic [7:0] idx;
         idx = {1'b0, offs_i} + 8'(b);
         // Bytes past the end of the line belong to the next line; they are
         // zero here and supplied by the merge on the second read.
         if (idx < 8'(LINE_BYTES)) begin
            raw_o[8*b +: 8] = line_i[{idx[6:0], 3'b000} +: 8];
         end
      end
   end

   assign held_mask = ~(64'hFFFF_FFFF_FFFF_FFFF << {held_cnt_i, 3'b000});
   assign merged    = (held_i & held_mask) | (raw_o << {held_cnt_i, 3'b000});

   always_comb begin
      data_o = merged;
      case (size_i)
         SIZE_B:  data_o = {{56{signed_i & merged[7]}},  merged[7:0]};
         SIZE_H:  data_o = {{48{signed_i & merged[15]}}, merged[15:0]};
         SIZE_W:  data_o = {{32{signed_i & merged[31]}}, merged[31:0]};
         default: data_o = merged;
      endcase
   end

endmodule

// File: rtl/ram_line_extractor.sv
// rtl/ram_line_extractor.sv - scalar load extraction from a 1024-bit block RAM read port
//
// Purpose : accepts byte-addressed 1/2/4/8-byte loads, drives the RAM read
//           port, and returns a 64-bit extended element two cycles later
//           (three for loads straddling two lines, which take two reads).
// Ports   :
//   CLK, RESET                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake
//   req_addrs [ADDRS_WIDTH+6:0]     byte address (line, offset[6:0])
//   req_size, req_signed, req_tag   load size, extension mode, opaque tag
//   rden, rdaddrs                   RAM read enable and line address
//   rddata [1023:0]                 RAM line, valid one cycle after rden
//   rsp_valid, rsp_data, rsp_tag    one-cycle response strobe, held data/tag
module ram_line_extractor
   import ram_line_pkg::*;
#(
   parameter int ADDRS_WIDTH = 12,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDRS_WIDTH+6:0] req_addrs,
   input  logic [1:0]             req_size,
   input  logic                   req_signed,
   input  logic [TAG_WIDTH-1:0]   req_tag,
   output logic                   rden,
   output logic [ADDRS_WIDTH-1:0] rdaddrs,
   input  logic [LINE_BITS-1:0]   rddata,
   output logic                   rsp_valid,
   output logic [63:0]            rsp_data,
   output logic [TAG_WIDTH-1:0]   rsp_tag
);

   state_e                 state_q, state_d;
   logic                   accept;
   logic [OFFS_WIDTH-1:0]  req_offs;
   logic [ADDRS_WIDTH-1:0] req_line;
   logic                   req_split;

   // Request info for the cycle the first line arrives; it stays put through
   // the merge cycle because nothing is accepted while in SECOND.
   logic                   s1_valid_q;
   logic                   s1_split_q;
   logic [OFFS_WIDTH-1:0]  s1_offs_q;
   logic [1:0]             s1_size_q;
   logic                   s1_signed_q;
   logic [TAG_WIDTH-1:0]   s1_tag_q;
   logic [ADDRS_WIDTH-1:0] line_q;

   logic                   m_valid_q;
   logic [63:0]            hold_q;

   logic                   rsp_valid_q;
   logic [63:0]            rsp_data_q;
   logic [TAG_WIDTH-1:0]   rsp_tag_q;

   logic [OFFS_WIDTH-1:0]  ext_offs;
   logic [2:0]             ext_held_cnt;
   logic [2:0]             split_held_cnt;
   logic [63:0]            ext_raw;
   logic [63:0]            ext_data;
   logic                   produce;

   assign req_offs  = req_addrs[OFFS_WIDTH-1:0];
   assign req_line  = req_addrs[ADDRS_WIDTH+6:OFFS_WIDTH];
   assign req_split = ({1'b0, req_offs} + {4'b0000, size_bytes(req_size)}) > 8'(LINE_BYTES);

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      accept    = 1'b0;
      rden      = 1'b0;
      rdaddrs   = req_line;
      case (state_q)
         ST_IDLE: begin
            req_ready = !RESET;
            accept    = req_valid && !RESET;
            rden      = accept;
            if (accept && req_split) begin
               state_d = ST_SECOND;
            end
         end
         ST_SECOND: begin
            rden    = !RESET;
            // Natural wrap: the last line is followed by line 0.
            rdaddrs = line_q + {{(ADDRS_WIDTH-1){1'b0}}, 1'b1};
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Held byte count of a split is 128-o, which for o in 121..127 equals
   // -o modulo 8 (7..1).
   assign split_held_cnt = 3'd0 - s1_offs_q[2:0];

   // Merge cycle: the second line is read from byte 0, above the held bytes.
   // Otherwise the first-read line is read at the request offset.
   assign ext_offs     = m_valid_q ? '0 : s1_offs_q;
   assign ext_held_cnt = m_valid_q ? split_held_cnt : 3'd0;
   assign produce      = m_valid_q || (s1_valid_q && !s1_split_q);

   byte_lane_extract u_lane (
      .line_i     (rddata),
      .offs_i     (ext_offs),
      .size_i     (s1_size_q),
      .signed_i   (s1_signed_q),
      .held_i     (hold_q),
      .held_cnt_i (ext_held_cnt),
      .raw_o      (ext_raw),
      .data_o     (ext_data)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         s1_valid_q  <= 1'b0;
         s1_split_q  <= 1'b0;
         s1_offs_q   <= '0;
         s1_size_q   <= 2'd0;
         s1_signed_q <= 1'b0;
         s1_tag_q    <= '0;
         line_q      <= '0;
         m_valid_q   <= 1'b0;
         hold_q      <= 64'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 64'd0;
         rsp_tag_q   <= '0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= accept;
         if (accept) begin
            s1_split_q  <= req_split;
            s1_offs_q   <= req_offs;
            s1_size_q   <= req_size;
            s1_signed_q <= req_signed;
            s1_tag_q    <= req_tag;
            line_q      <= req_line;
         end
         m_valid_q <= s1_valid_q && s1_split_q;
         // Bytes o..127 of the first line, packed from bit 0 up.
         if (s1_valid_q && s1_split_q) begin
            hold_q <= ext_raw;
         end
         rsp_valid_q <= produce;
         if (produce) begin
            rsp_data_q <= ext_data;
            rsp_tag_q  <= s1_tag_q;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_ram_line_extractor.sv
// tb/tb_ram_line_extractor.sv - directed self-checking bench for ram_line_extractor
module tb_ram_line_extractor;

   localparam int AW = 12;
   localparam int TW = 4;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW+6:0] req_addrs = '0;
   logic [1:0]    req_size = 2'd0;
   logic          req_signed = 1'b0;
   logic [TW-1:0] req_tag = '0;
   logic          rden;
   logic [AW-1:0] rdaddrs;
   logic [1023:0] rddata = '0;
   logic          rsp_valid;
   logic [63:0]   rsp_data;
   logic [TW-1:0] rsp_tag;

   logic [1023:0] mem [0:4095];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (rden) rddata <= mem[rdaddrs];
   end

   ram_line_extractor #(.ADDRS_WIDTH(AW), .TAG_WIDTH(TW)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addrs  (req_addrs),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_tag    (req_tag),
      .rden       (rden),
      .rdaddrs    (rdaddrs),
      .rddata     (rddata),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_tag    (rsp_tag)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   task automatic put_req(input logic [AW+6:0] a, input logic [1:0] s, input logic sg, input logic [TW-1:0] t);
      req_valid  = 1'b1;
      req_addrs  = a;
      req_size   = s;
      req_signed = sg;
      req_tag    = t;
   endtask

   task automatic single(input string nm, input logic [AW+6:0] a, input logic [1:0] s, input logic sg,
                         input logic [TW-1:0] t, input logic [AW-1:0] line, input logic [63:0] exp);
      @(negedge CLK); put_req(a, s, sg, t); #1;
      chk({nm, ".rden"}, 64'(rden), 64'd1);
      chk({nm, ".rdaddrs"}, 64'(rdaddrs), 64'(line));
      chk({nm, ".ready"}, 64'(req_ready), 64'd1);
      @(negedge CLK); req_valid = 1'b0; #1;
      chk({nm, ".early"}, 64'(rsp_valid), 64'd0);
      @(negedge CLK); #1;
      chk({nm, ".valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, ".data"}, rsp_data, exp);
      chk({nm, ".tag"}, 64'(rsp_tag), 64'(t));
   endtask

   task automatic split(input string nm, input logic [AW+6:0] a, input logic [1:0] s, input logic sg,
                        input logic [TW-1:0] t, input logic [AW-1:0] l1, input logic [AW-1:0] l2,
                        input logic [63:0] exp);
      @(negedge CLK); put_req(a, s, sg, t); #1;
      chk({nm, ".rdaddrs0"}, 64'(rdaddrs), 64'(l1));
      chk({nm, ".rden0"}, 64'(rden), 64'd1);
      @(negedge CLK); req_valid = 1'b0; #1;
      chk({nm, ".rdaddrs1"}, 64'(rdaddrs), 64'(l2));
      chk({nm, ".rden1"}, 64'(rden), 64'd1);
      chk({nm, ".ready1"}, 64'(req_ready), 64'd0);
      @(negedge CLK); #1;
      chk({nm, ".early"}, 64'(rsp_valid), 64'd0);
      chk({nm, ".ready2"}, 64'(req_ready), 64'd1);
      @(negedge CLK); #1;
      chk({nm, ".valid"}, 64'(rsp_valid), 64'd1);
      chk({nm, ".data"}, rsp_data, exp);
      chk({nm, ".tag"}, 64'(rsp_tag), 64'(t));
   endtask

   initial begin
      for (int l = 0; l < 4096; l++) mem[l] = '0;
      for (int k = 0; k < 128; k++) begin
         mem[3][8*k +: 8]    = 8'(k);
         mem[4][8*k +: 8]    = 8'(8'h80 + k);
         mem[4095][8*k +: 8] = 8'(8'h40 + k);
         mem[0][8*k +: 8]    = 8'(8'hC0 + k);
      end

      // Reset state
      repeat (2) @(negedge CLK);
      #1;
      chk("rst.ready", 64'(req_ready), 64'd0);
      chk("rst.rden", 64'(rden), 64'd0);
      chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst.rsp_data", rsp_data, 64'd0);
      chk("rst.rsp_tag", 64'(rsp_tag), 64'd0);
      @(negedge CLK); RESET = 1'b0; #1;
      chk("rst.ready_rel", 64'(req_ready), 64'd1);

      // Aligned, then sign/zero extension at a line boundary
      single("aligned", 19'h188, 2'd3, 1'b0, 4'd5, 12'd3, 64'h0F0E0D0C0B0A0908);
      @(negedge CLK); #1;
      chk("hold.valid", 64'(rsp_valid), 64'd0);
      chk("hold.data", rsp_data, 64'h0F0E0D0C0B0A0908);
      chk("hold.tag", 64'(rsp_tag), 64'd5);
      single("sgn7f", 19'h1FF, 2'd0, 1'b1, 4'd1, 12'd3, 64'h000000000000007F);
      single("sgn80", 19'h200, 2'd0, 1'b1, 4'd2, 12'd4, 64'hFFFFFFFFFFFFFF80);
      single("uns80", 19'h200, 2'd0, 1'b0, 4'd3, 12'd4, 64'h0000000000000080);
      single("dsgn", 19'h278, 2'd3, 1'b1, 4'd4, 12'd4, 64'hFFFEFDFCFBFAF9F8);

      // Split loads, including last-line wrap and a single held byte
      split("split", 19'h1FE, 2'd2, 1'b0, 4'd6, 12'd3, 12'd4, 64'h0000000081807F7E);
      split("wrap", 19'(4095*128 + 124), 2'd3, 1'b0, 4'd7, 12'd4095, 12'd0, 64'hC3C2C1C0BFBEBDBC);
      split("splith", 19'h1FF, 2'd1, 1'b1, 4'd8, 12'd3, 12'd4, 64'hFFFFFFFFFFFF807F);

      // Split followed by a held request accepted two cycles later
      @(negedge CLK); put_req(19'h1FE, 2'd2, 1'b0, 4'd6); #1;
      chk("b2b.rden0", 64'(rden), 64'd1);
      @(negedge CLK); put_req(19'h188, 2'd3, 1'b0, 4'd7); #1;
      chk("b2b.ready1", 64'(req_ready), 64'd0);
      chk("b2b.rdaddrs1", 64'(rdaddrs), 64'd4);
      @(negedge CLK); #1;
      chk("b2b.ready2", 64'(req_ready), 64'd1);
      chk("b2b.rdaddrs2", 64'(rdaddrs), 64'd3);
      chk("b2b.early", 64'(rsp_valid), 64'd0);
      @(negedge CLK); req_valid = 1'b0; #1;
      chk("b2b.v0", 64'(rsp_valid), 64'd1);
      chk("b2b.tag0", 64'(rsp_tag), 64'd6);
      chk("b2b.data0", rsp_data, 64'h0000000081807F7E);
      @(negedge CLK); #1;
      chk("b2b.v1", 64'(rsp_valid), 64'd1);
      chk("b2b.tag1", 64'(rsp_tag), 64'd7);
      chk("b2b.data1", rsp_data, 64'h0F0E0D0C0B0A0908);

      // Streaming: four aligned words on consecutive cycles
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (i < 4) put_req(19'(3*128 + 4*i), 2'd2, 1'b0, 4'(i + 1));
         else req_valid = 1'b0;
         #1;
         if (i < 4) chk($sformatf("stream.ready%0d", i), 64'(req_ready), 64'd1);
         if (i >= 2) begin
            chk($sformatf("stream.valid%0d", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("stream.tag%0d", i), 64'(rsp_tag), 64'(i - 1));
            chk($sformatf("stream.data%0d", i), rsp_data,
                {32'd0, 8'(4*i-5), 8'(4*i-6), 8'(4*i-7), 8'(4*i-8)});
         end
      end
      @(negedge CLK); #1;
      chk("stream.done", 64'(rsp_valid), 64'd0);

      // Reset during the SECOND cycle drops the split
      @(negedge CLK); put_req(19'h1FE, 2'd2, 1'b0, 4'd9); #1;
      chk("rsplit.rden0", 64'(rden), 64'd1);
      @(negedge CLK); req_valid = 1'b0; RESET = 1'b1; #1;
      chk("rsplit.rden", 64'(rden), 64'd0);
      chk("rsplit.ready", 64'(req_ready), 64'd0);
      @(negedge CLK); #1;
      chk("rsplit.rden_b", 64'(rden), 64'd0);
      chk("rsplit.ready_b", 64'(req_ready), 64'd0);
      chk("rsplit.valid_b", 64'(rsp_valid), 64'd0);
      @(negedge CLK); RESET = 1'b0; #1;
      chk("rsplit.ready_rel", 64'(req_ready), 64'd1);
      chk("rsplit.data_rst", rsp_data, 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK); #1;
         chk($sformatf("rsplit.novalid%0d", i), 64'(rsp_valid), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
